// File: rtl/cmd_sequencer_if.sv
// cmd_sequencer_if
// Bundles the command pulses, register-file bus and LED status lines of the
// command sequencer.
//   master : sequencer side (drives register-file bus and status)
//   slave  : environment side (edge detectors, register file, LEDs)
interface cmd_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              cmd_clear;
    logic              cmd_write;
    logic              cmd_read;
    logic              cmd_inc;
    logic              cmd_dec;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ptr;
    logic              busy;
    logic              cmd_drop;
    logic [2:0]        state_out;

    modport master (
        input  cmd_clear, cmd_write, cmd_read, cmd_inc, cmd_dec, wdata_in, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, rd_data, ptr, busy, cmd_drop, state_out
    );

    modport slave (
        output cmd_clear, cmd_write, cmd_read, cmd_inc, cmd_dec, wdata_in, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, rd_data, ptr, busy, cmd_drop, state_out
    );
endinterface

// File: rtl/cmd_sequencer.sv
// cmd_sequencer
// Arbitrates one-cycle command pulses (clear > write > read > inc > dec) and
// sequences a synchronous register file through clear, write and read
// operations while maintaining a wrapping address pointer.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : cmd_sequencer_if.master (commands, register-file bus, status)
module cmd_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    cmd_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ      = 3'd3;
    localparam logic [2:0] S_READ_WAIT = 3'd4;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    logic              drop_q;

    logic [4:0] cmds;
    logic       multi;

    assign cmds  = {bus.cmd_clear, bus.cmd_write, bus.cmd_read, bus.cmd_inc, bus.cmd_dec};
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi = |(cmds & (cmds - 5'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            // In IDLE only the losers of arbitration are dropped; elsewhere
            // every command is dropped.
            drop_q <= (state == S_IDLE) ? multi : |cmds;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_clear) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end else if (bus.cmd_write) begin
                        state   <= S_WRITE;
                        wdata_q <= bus.wdata_in;
                    end else if (bus.cmd_read) begin
                        state <= S_READ;
                    end else if (bus.cmd_inc) begin
                        ptr <= ptr + ONE;
                    end else if (bus.cmd_dec) begin
                        ptr <= ptr - ONE;
                    end
                end
                S_CLEAR: begin
                    if (&cnt) begin
                        ptr   <= '0;
                        rd_q  <= '0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_WRITE:     state <= S_IDLE;
                S_READ:      state <= S_READ_WAIT;
                S_READ_WAIT: begin
                    rd_q  <= bus.mem_rdata;
                    state <= S_IDLE;
                end
                default:     state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    // ptr cannot move during WRITE/READ (inc/dec are dropped), so it is the
    // address captured at acceptance.
    assign bus.mem_we    = (state == S_WRITE) || (state == S_CLEAR);
    assign bus.mem_re    = (state == S_READ);
    assign bus.mem_wdata = (state == S_WRITE) ? wdata_q : '0;
    assign bus.mem_addr  = (state == S_CLEAR) ? cnt : ptr;
    assign bus.rd_data   = rd_q;
    assign bus.ptr       = ptr;
    assign bus.busy      = (state != S_IDLE);
    assign bus.cmd_drop  = drop_q;
    assign bus.state_out = state;
endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int N      = 1 << ADDR_W;

    localparam logic [4:0] C_CLR = 5'b10000;
    localparam logic [4:0] C_WR  = 5'b01000;
    localparam logic [4:0] C_RD  = 5'b00100;
    localparam logic [4:0] C_INC = 5'b00010;
    localparam logic [4:0] C_DEC = 5'b00001;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_DR = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic clk;
    logic reset;
    cmd_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cmd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  sq[$];
    logic [DATA_W-1:0] mem [N];

    // Register-file model: synchronous write, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int a, input int d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        sq.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input int a, input int d);
        ev_t e;
        if (sq.size() == 0) begin
            chk("unexpected_event_kind", k, 32'hFFFF_FFFF);
        end else begin
            e = sq.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_addr", a, e.addr);
            chk("event_data", d, e.data);
        end
    endtask

    // Monitor: every strobe/drop the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we)   pop_cmp(K_WR, int'(bus.mem_addr), int'(bus.mem_wdata));
            if (bus.mem_re)   pop_cmp(K_RD, int'(bus.mem_addr), 0);
            if (bus.cmd_drop) pop_cmp(K_DR, 0, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] c, input logic [DATA_W-1:0] d);
        {bus.cmd_clear, bus.cmd_write, bus.cmd_read, bus.cmd_inc, bus.cmd_dec} = c;
        bus.wdata_in = d;
        step();
        {bus.cmd_clear, bus.cmd_write, bus.cmd_read, bus.cmd_inc, bus.cmd_dec} = 5'b0;
    endtask

    // Write 0x11..0x88 into entries 0..7; pointer walks round back to 0.
    task automatic fill();
        for (int i = 0; i < N; i++) begin
            push(K_WR, i, (i + 1) * 17);
            pulse(C_WR, 8'((i + 1) * 17));
            step();
            pulse(C_INC, 8'h00);
        end
        chk("fill_ptr_wrap", bus.ptr, 0);
    endtask

    task automatic do_read(input int addr, input logic [DATA_W-1:0] exp);
        push(K_RD, addr, 0);
        pulse(C_RD, 8'h00);
        chk("read_state_n1", bus.state_out, 3);
        step();
        chk("read_state_n2", bus.state_out, 4);
        step();
        chk("read_state_n3", bus.state_out, 0);
        chk("read_rd_data", bus.rd_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        {bus.cmd_clear, bus.cmd_write, bus.cmd_read, bus.cmd_inc, bus.cmd_dec} = 5'b0;
        bus.wdata_in  = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) step();

        chk("rst_state", bus.state_out, 0);
        chk("rst_ptr", bus.ptr, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop", bus.cmd_drop, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        step();

        // Single write of 0xA5 at address 0, busy for exactly one cycle.
        push(K_WR, 0, 8'hA5);
        pulse(C_WR, 8'hA5);
        chk("wr_busy_n1", bus.busy, 1);
        chk("wr_state_n1", bus.state_out, 2);
        step();
        chk("wr_busy_n2", bus.busy, 0);
        chk("wr_state_n2", bus.state_out, 0);

        do_read(0, 8'hA5);

        // Pointer wrap in both directions.
        pulse(C_DEC, 8'h00);
        chk("dec_wrap_ptr", bus.ptr, 7);
        chk("dec_busy", bus.busy, 0);
        repeat (N) pulse(C_INC, 8'h00);
        chk("inc8_ptr", bus.ptr, 7);
        pulse(C_INC, 8'h00);
        chk("inc_wrap_ptr", bus.ptr, 0);

        // write+inc together: write wins, inc dropped; read during WRITE dropped.
        push(K_WR, 0, 8'h3C);
        push(K_DR, 0, 0);
        push(K_DR, 0, 0);
        pulse(C_WR | C_INC, 8'h3C);
        chk("arb_state_write", bus.state_out, 2);
        pulse(C_RD, 8'h00);
        chk("arb_state_idle", bus.state_out, 0);
        chk("arb_ptr_unchanged", bus.ptr, 0);
        step();

        // Full clear after filling.
        fill();
        for (int i = 0; i < N; i++) push(K_WR, i, 0);
        pulse(C_CLR, 8'h00);
        chk("clr_state", bus.state_out, 1);
        chk("clr_busy", bus.busy, 1);
        repeat (N) step();
        chk("clr_done_state", bus.state_out, 0);
        chk("clr_ptr", bus.ptr, 0);
        chk("clr_rd_data", bus.rd_data, 0);
        do_read(0, 8'h00);
        repeat (5) pulse(C_INC, 8'h00);
        do_read(5, 8'h00);
        pulse(C_INC, 8'h00);
        pulse(C_INC, 8'h00);
        pulse(C_INC, 8'h00);
        chk("ptr_back_to_0", bus.ptr, 0);

        // Reset in the middle of a clear (counter = 3).
        fill();
        push(K_WR, 0, 0);
        push(K_WR, 1, 0);
        push(K_WR, 2, 0);
        pulse(C_CLR, 8'h00);
        repeat (3) step();
        chk("midclr_we_before", bus.mem_we, 1);
        chk("midclr_addr_before", bus.mem_addr, 3);
        reset = 1'b1;
        #1;
        chk("midclr_we", bus.mem_we, 0);
        chk("midclr_state", bus.state_out, 0);
        chk("midclr_ptr", bus.ptr, 0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < N; i++)
            chk("midclr_mem", mem[i], (i < 3) ? 0 : (i + 1) * 17);
        repeat (3) pulse(C_INC, 8'h00);
        do_read(3, 8'h44);

        repeat (3) step();
        chk("queue_empty", sq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command sequencer for the pushbutton-driven memory datapath. It accepts single-cycle command pulses from the button edge detectors and arbitrates simultaneous commands by fixed priority. It then sequences a small synchronous register file through clear, write and read operations, and maintains the address pointer with wrap-around. It sits between the edge detectors and the register file; its status outputs drive the LED indicators.

## Interface
- ADDR_W, 3, address width; register file depth N = 2^ADDR_W
- DATA_W, 8, data width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_clear  in  1  one-cycle pulse: zero entire register file
- cmd_write  in  1  one-cycle pulse: write wdata_in at pointer
- cmd_read  in  1  one-cycle pulse: read entry at pointer
- cmd_inc  in  1  one-cycle pulse: pointer + 1
- cmd_dec  in  1  one-cycle pulse: pointer - 1
- wdata_in  in  DATA_W  write data, sampled in the accept cycle
- mem_rdata  in  DATA_W  register file read data, valid the cycle after mem_re
- mem_addr  out  ADDR_W  register file address
- mem_wdata  out  DATA_W  register file write data
- mem_we  out  1  register file write strobe
- mem_re  out  1  register file read strobe
- rd_data  out  DATA_W  last captured read value
- ptr  out  ADDR_W  current address pointer
- busy  out  1  high whenever state != IDLE
- cmd_drop  out  1  one-cycle pulse when any command is discarded
- state_out  out  3  state encoding for LEDs

## Operation
- States: IDLE=0, CLEAR=1, WRITE=2, READ=3, READ_WAIT=4. Encodings 5-7 are illegal and go to IDLE on the next clock.
- Arbitration occurs only in IDLE. Priority: clear > write > read > inc > dec. The highest asserted command is accepted; every other asserted command is dropped, and cmd_drop pulses in that same cycle.
- Commands asserted in any state other than IDLE are dropped with a cmd_drop pulse. There is no queue.
- inc/dec: accepted in IDLE without leaving IDLE. ptr updates on the next edge, modulo N: (N-1)+1 wraps to 0, 0-1 wraps to N-1.
- WRITE: wdata_in and ptr are registered at acceptance. For one cycle mem_we=1, mem_addr=ptr, mem_wdata=registered data. Then IDLE.
- READ: for one cycle mem_re=1, mem_addr=ptr. Then READ_WAIT: mem_rdata is captured into rd_data at the end of this cycle. Then IDLE.
- CLEAR: an internal counter steps 0..N-1. Each CLEAR cycle drives mem_we=1, mem_addr=counter, mem_wdata=0. On the last entry, ptr<=0 and rd_data<=0, then IDLE.
- Outside their active states, mem_we=0 and mem_re=0. mem_wdata=0 except in WRITE. mem_addr=ptr except in CLEAR.
- Width rules: ptr and counter are unsigned ADDR_W bits with natural wrap. No arithmetic is performed on data.

## Timing
- Reset values (asynchronous, immediate): state IDLE, ptr=0, counter=0, rd_data=0, mem_we=0, mem_re=0, mem_wdata=0, mem_addr=0, busy=0, cmd_drop=0, state_out=0.
- Command sampled at edge n (cycle n): the new state is visible in cycle n+1.
- Write: mem_we high in cycle n+1 only; IDLE again in n+2.
- Read: mem_re high in n+1; mem_rdata sampled at end of n+2; rd_data valid from n+3; IDLE in n+3.
- Clear: mem_we high in cycles n+1..n+N; ptr=0 from n+N+1; IDLE in n+N+1.
- inc/dec: ptr changes in n+1; busy stays 0.
- A command is accepted in the same cycle the state returns to IDLE; back-to-back accepts are possible every 2 cycles for write and every 3 for read.
- cmd_drop is combinational from the command inputs and the state, or registered one cycle later. It is registered: it pulses in cycle n+1 for drops at edge n.
- Reset asserted mid-operation aborts immediately. A partially cleared memory is not completed, and strobes drop asynchronously.

## Test plan
- Reset then pulse cmd_write with wdata_in=0xA5, ptr=0 -> one cycle mem_we=1, mem_addr=0, mem_wdata=0xA5; busy high exactly 1 cycle.
- After that write, cmd_read -> mem_re=1 addr 0, then rd_data=0xA5 two cycles after mem_re; state_out sequence 3,4,0.
- From ptr=0, cmd_dec -> ptr=7 (ADDR_W=3); then 8× cmd_inc -> ptr=7 again; then cmd_inc -> ptr=0.
- cmd_write and cmd_inc in the same cycle -> write performed, ptr unchanged, cmd_drop pulses once. cmd_read pulsed during WRITE -> dropped, cmd_drop=1, no mem_re.
- Write 0x11..0x88 to addresses 0..7, then cmd_clear -> mem_we high 8 consecutive cycles with addr 0..7 and data 0; afterward ptr=0, rd_data=0, and reading any address returns 0.
- Start cmd_clear, assert reset at counter=3 -> mem_we=0 immediately, state_out=0, ptr=0; entries 3..7 retain their old values.
